marker_pixel_classifier: RTL and testbench

- Producer side of the marker-tracking interface. Consumes the decoded camera pixel stream, tracks the raster position of each pixel and classifies the pixel into one of four marker colours using YCrCb threshold boxes.
- Emits one `interesting_*` beat per qualified marker pixel.
- Raises `frame_flag` during vertical blanking so the downstream centroid/corner stage can divide and reset.
- Sits between the video decoder/ZBT reader and the object-recognition stage.

---
 rtl/augreal_pkg.sv | 34 +++
 rtl/color_box_match.sv | 40 ++++
 rtl/marker_pixel_classifier.sv | 148 ++++++++++++++
 tb/tb_marker_pixel_classifier.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/augreal_pkg.sv
// Shared geometry, colour indices, FSM encoding and the stage-1 beat payload
// used by the marker-tracking producer.
package augreal_pkg;

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned COLOR_W  = 2;
   localparam int unsigned X_W      = 10;
   localparam int unsigned Y_W      = 9;
   localparam int unsigned RUN_W    = 4;

   typedef enum logic [COLOR_W-1:0] {
      RED    = 2'd0,
      GREEN  = 2'd1,
      BLUE   = 2'd2,
      YELLOW = 2'd3
   } color_e;

   typedef enum logic {
      ACTIVE = 1'b0,
      BLANK  = 1'b1
   } state_e;

   // Classified pixel as it leaves stage 1
   typedef struct packed {
      logic [X_W-1:0]     x;
      logic [Y_W-1:0]     y;
      logic               match;
      logic [COLOR_W-1:0] idx;
      logic               sof;
      logic               eol;
   } class_beat_t;

endpackage

// File: rtl/color_box_match.sv
// Combinational YCrCb threshold-box compare for the four marker colours;
// the lowest matching colour index wins.
module color_box_match
   import augreal_pkg::*;
#(
   parameter logic [31:0] CR_LO = 32'h00_00_00_A0,
   parameter logic [31:0] CR_HI = 32'h00_00_00_FF,
   parameter logic [31:0] CB_LO = 32'h00_00_00_00,
   parameter logic [31:0] CB_HI = 32'h00_00_00_6E,
   parameter logic [7:0]  Y_MIN = 8'd32
) (
   input  logic [7:0]         y,
   input  logic [7:0]         cr,
   input  logic [7:0]         cb,
   output logic               match,
   output logic [COLOR_W-1:0] idx
);

   // a <= b via the borrow of a 9-bit subtraction
   function automatic logic le8(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] d;
      d = {1'b0, b} - {1'b0, a};
      return ~d[8];
   endfunction

   // Scan high to low so the lowest matching index is the one left standing
   always_comb begin
      match = 1'b0;
      idx   = '0;
      for (int n = 3; n >= 0; n--) begin
         if (le8(Y_MIN, y) &&
             le8(CR_LO[8*n +: 8], cr) && le8(cr, CR_HI[8*n +: 8]) &&
             le8(CB_LO[8*n +: 8], cb) && le8(cb, CB_HI[8*n +: 8])) begin
            match = 1'b1;
            idx   = COLOR_W'(n);
         end
      end
   end

endmodule

// File: rtl/marker_pixel_classifier.sv
// Raster tracking, colour classification and run filtering of the camera pixel
// stream; emits marker pixel beats and a vertical-blanking flag.
module marker_pixel_classifier #(
   parameter int unsigned H_ACTIVE = augreal_pkg::H_ACTIVE,
   parameter int unsigned V_ACTIVE = augreal_pkg::V_ACTIVE,
   parameter int unsigned RUN_MIN  = 3,
   parameter logic [31:0] CR_LO    = 32'h00_00_00_A0,
   parameter logic [31:0] CR_HI    = 32'h00_00_00_FF,
   parameter logic [31:0] CB_LO    = 32'h00_00_00_00,
   parameter logic [31:0] CB_HI    = 32'h00_00_00_6E,
   parameter logic [7:0]  Y_MIN    = 8'd32
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             pix_valid,
   input  logic                             pix_sof,
   input  logic                             pix_eol,
   input  logic [7:0]                       pix_y,
   input  logic [7:0]                       pix_cr,
   input  logic [7:0]                       pix_cb,
   output logic                             interesting_flag,
   output logic [augreal_pkg::X_W-1:0]      interesting_x,
   output logic [augreal_pkg::Y_W-1:0]      interesting_y,
   output logic [augreal_pkg::COLOR_W-1:0]  color,
   output logic                             frame_flag
);
   import augreal_pkg::*;

   localparam logic [X_W-1:0]   X_LAST  = X_W'(H_ACTIVE - 1);
   localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(V_ACTIVE - 1);
   localparam logic [RUN_W-1:0] RUN_MAX = '1;
   localparam logic [RUN_W-1:0] RUN_THR = RUN_W'(RUN_MIN);

   state_e             state, state_nxt;
   logic               frame_flag_nxt;
   logic               accept;
   logic [X_W-1:0]     pos_x, pos_x_nxt, cur_x;
   logic [Y_W-1:0]     pos_y, pos_y_nxt, cur_y;
   logic               box_match;
   logic [COLOR_W-1:0] box_idx;
   class_beat_t        s1_q;
   logic               s1_valid;
   logic [RUN_W-1:0]   run_cnt, run_cnt_nxt, base_cnt, new_cnt;
   logic [COLOR_W-1:0] run_color, run_color_nxt;
   logic               report;

   color_box_match #(
      .CR_LO (CR_LO),
      .CR_HI (CR_HI),
      .CB_LO (CB_LO),
      .CB_HI (CB_HI),
      .Y_MIN (Y_MIN)
   ) u_match (
      .y     (pix_y),
      .cr    (pix_cr),
      .cb    (pix_cb),
      .match (box_match),
      .idx   (box_idx)
   );

   // Beat acceptance, raster position and ACTIVE/BLANK next state
   always_comb begin
      state_nxt      = state;
      accept         = 1'b0;
      cur_x          = pos_x;
      cur_y          = pos_y;
      pos_x_nxt      = pos_x;
      pos_y_nxt      = pos_y;
      frame_flag_nxt = 1'b0;
      if (pix_sof) begin
         cur_x = '0;
         cur_y = '0;
      end
      accept = pix_valid && ((state == ACTIVE) || pix_sof);
      if (accept) begin
         if (pix_eol) begin
            pos_x_nxt = '0;
            pos_y_nxt = (cur_y == Y_LAST) ? Y_LAST : cur_y + 1'b1;
         end else begin
            pos_x_nxt = (cur_x == X_LAST) ? X_LAST : cur_x + 1'b1;
            pos_y_nxt = cur_y;
         end
         state_nxt = (pix_eol && (cur_y == Y_LAST)) ? BLANK : ACTIVE;
      end
      frame_flag_nxt = (state_nxt == BLANK);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ACTIVE;
         frame_flag <= 1'b0;
         pos_x      <= '0;
         pos_y      <= '0;
         s1_valid   <= 1'b0;
         s1_q       <= '0;
      end else begin
         state      <= state_nxt;
         frame_flag <= frame_flag_nxt;
         pos_x      <= pos_x_nxt;
         pos_y      <= pos_y_nxt;
         s1_valid   <= accept;
         if (accept) begin
            s1_q <= '{x: cur_x, y: cur_y, match: box_match, idx: box_idx,
                      sof: pix_sof, eol: pix_eol};
         end
      end
   end

   // Stage-2 run filter; sof clears the run before the pixel counts
   always_comb begin
      base_cnt      = s1_q.sof ? '0 : run_cnt;
      new_cnt       = '0;
      run_color_nxt = run_color;
      if (s1_q.match) begin
         if ((s1_q.idx == run_color) && (base_cnt != '0)) begin
            new_cnt = (base_cnt == RUN_MAX) ? RUN_MAX : base_cnt + 1'b1;
         end else begin
            run_color_nxt = s1_q.idx;
            new_cnt       = RUN_W'(1);
         end
      end
      run_cnt_nxt = s1_q.eol ? '0 : new_cnt;
      report      = s1_valid && s1_q.match && (new_cnt >= RUN_THR);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_cnt          <= '0;
         run_color        <= '0;
         interesting_flag <= 1'b0;
         interesting_x    <= '0;
         interesting_y    <= '0;
         color            <= '0;
      end else begin
         if (s1_valid) begin
            run_cnt   <= run_cnt_nxt;
            run_color <= run_color_nxt;
         end
         interesting_flag <= report;
         if (report) begin
            interesting_x <= s1_q.x;
            interesting_y <= s1_q.y;
            color         <= s1_q.idx;
         end
      end
   end

endmodule

// File: tb/tb_marker_pixel_classifier.sv
// Bench for marker_pixel_classifier: two instances (RUN_MIN=3 and RUN_MIN=1)
// share one stimulus table; a per-instance queue holds the expected pulses.
module tb_marker_pixel_classifier;

   localparam int K_NONE = 0;
   localparam int K_C0   = 1;
   localparam int K_G    = 2;
   localparam int K_DARK = 3;
   localparam int K_EDGE = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       pix_valid = 1'b0, pix_sof = 1'b0, pix_eol = 1'b0;
   logic [7:0] pix_y = '0, pix_cr = '0, pix_cb = '0;

   logic       flag3, flag1, ff3, ff1;
   logic [9:0] x3, x1;
   logic [8:0] y3, y1;
   logic [1:0] c3, c1;

   int cyc = 0;
   int checks = 0;
   int passes = 0;

   typedef struct {int due; int x; int y; int c;} exp_t;
   exp_t q3[$];
   exp_t q1[$];

   typedef struct {
      int rep; bit v; bit sof; bit eol; int kind;
      bit e3; bit e1; int ex; int ey; int ec; int ff;
   } vec_t;
   vec_t vecs[$];

   marker_pixel_classifier dut3 (
      .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_sof(pix_sof),
      .pix_eol(pix_eol), .pix_y(pix_y), .pix_cr(pix_cr), .pix_cb(pix_cb),
      .interesting_flag(flag3), .interesting_x(x3), .interesting_y(y3),
      .color(c3), .frame_flag(ff3));

   marker_pixel_classifier #(.RUN_MIN(1)) dut1 (
      .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_sof(pix_sof),
      .pix_eol(pix_eol), .pix_y(pix_y), .pix_cr(pix_cr), .pix_cb(pix_cb),
      .interesting_flag(flag1), .interesting_x(x1), .interesting_y(y1),
      .color(c1), .frame_flag(ff1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act == expv) passes++;
      else $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, expv, cyc);
   endtask

   task automatic mon_one(input int id, input logic f, input logic [9:0] x,
                          input logic [8:0] y, input logic [1:0] c);
      exp_t e;
      bit   ef;
      ef = 1'b0;
      e  = '{0, 0, 0, 0};
      if (id == 0) begin
         if (q3.size() > 0 && q3[0].due == cyc) begin ef = 1'b1; e = q3.pop_front(); end
      end else begin
         if (q1.size() > 0 && q1[0].due == cyc) begin ef = 1'b1; e = q1.pop_front(); end
      end
      if (ef || f) begin
         checks++;
         if (ef && f && x == 10'(e.x) && y == 9'(e.y) && c == 2'(e.c)) passes++;
         else $display("FAIL pulse dut%0d cyc %0d: got flag=%0b x=%0d y=%0d c=%0d, expected flag=%0b x=%0d y=%0d c=%0d",
                       (id == 0) ? 3 : 1, cyc, f, x, y, c, ef, e.x, e.y, e.c);
      end
   endtask

   always @(negedge clk) begin
      mon_one(0, flag3, x3, y3, c3);
      mon_one(1, flag1, x1, y1, c1);
   end

   task automatic set_pix(input int kind);
      case (kind)
         K_C0:    begin pix_y = 8'd100; pix_cr = 8'd200; pix_cb = 8'd50;  end
         K_G:     begin pix_y = 8'd100; pix_cr = 8'd0;   pix_cb = 8'd0;   end
         K_DARK:  begin pix_y = 8'd31;  pix_cr = 8'd200; pix_cb = 8'd50;  end
         K_EDGE:  begin pix_y = 8'd32;  pix_cr = 8'd160; pix_cb = 8'd110; end
         default: begin pix_y = 8'd100; pix_cr = 8'd128; pix_cb = 8'd128; end
      endcase
   endtask

   function automatic void add(input int rep, input bit v, input bit sof, input bit eol,
                               input int kind, input bit e3, input bit e1,
                               input int ex, input int ey, input int ec, input int ff);
      vec_t r;
      r.rep = rep; r.v = v; r.sof = sof; r.eol = eol; r.kind = kind;
      r.e3 = e3; r.e1 = e1; r.ex = ex; r.ey = ey; r.ec = ec; r.ff = ff;
      vecs.push_back(r);
   endfunction

   task automatic beat(input bit sof, input bit eol, input int kind, input bit e3,
                       input bit e1, input int ex, input int ey);
      @(negedge clk);
      pix_valid = 1'b1; pix_sof = sof; pix_eol = eol;
      set_pix(kind);
      if (e3) q3.push_back('{cyc + 2, ex, ey, 0});
      if (e1) q1.push_back('{cyc + 2, ex, ey, 0});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0;
      end
   endtask

   initial begin
      // rep, v, sof, eol, kind, e3, e1, x, y, colour, frame_flag (2 = unchecked)
      add(1,   1, 1, 0, K_C0,   0, 1, 0, 0, 0, 0);
      add(7,   1, 0, 1, K_NONE, 0, 0, 0, 0, 0, 2);
      add(100, 1, 0, 0, K_NONE, 0, 0, 0, 0, 0, 2);
      for (int i = 0; i < 5; i++) add(1, 1, 0, 0, K_C0, (i >= 2), 1, 100 + i, 7, 0, 2);
      add(1, 1, 0, 0, K_NONE, 0, 0, 0, 0, 0, 2);
      add(1, 1, 0, 0, K_C0,   0, 1, 106, 7, 0, 2);
      add(1, 1, 0, 0, K_C0,   0, 1, 107, 7, 0, 2);
      add(1, 1, 0, 0, K_NONE, 0, 0, 0, 0, 0, 2);
      add(1, 1, 0, 0, K_C0,   0, 1, 109, 7, 0, 2);
      add(1, 1, 0, 0, K_C0,   0, 1, 110, 7, 0, 2);
      add(1, 1, 0, 0, K_NONE, 0, 0, 0, 0, 0, 2);
      add(1, 1, 0, 0, K_C0,   0, 1, 112, 7, 0, 2);
      add(1, 1, 0, 0, K_C0,   0, 1, 113, 7, 0, 2);
      add(2, 0, 0, 0, K_C0,   0, 0, 0, 0, 0, 2);
      add(1, 1, 0, 0, K_C0,   1, 1, 114, 7, 0, 2);
      add(1, 0, 0, 0, K_C0,   0, 0, 0, 0, 0, 2);
      add(1, 1, 0, 0, K_C0,   1, 1, 115, 7, 0, 2);
      add(1, 1, 0, 0, K_NONE, 0, 0, 0, 0, 0, 2);
      add(521, 1, 0, 0, K_NONE, 0, 0, 0, 0, 0, 2);
      add(1, 1, 0, 0, K_C0,   0, 1, 638, 7, 0, 2);
      add(1, 1, 0, 1, K_C0,   0, 1, 639, 7, 0, 2);
      add(1, 1, 0, 0, K_C0,   0, 1, 0, 8, 0, 2);
      add(1, 1, 0, 0, K_C0,   0, 1, 1, 8, 0, 2);
      add(1, 1, 0, 0, K_G,    0, 1, 2, 8, 1, 2);
      add(1, 1, 0, 0, K_G,    0, 1, 3, 8, 1, 2);
      add(1, 1, 0, 0, K_G,    1, 1, 4, 8, 1, 2);
      add(1, 1, 0, 0, K_C0,   0, 1, 5, 8, 0, 2);
      add(1, 1, 0, 0, K_C0,   0, 1, 6, 8, 0, 2);
      add(1, 1, 0, 0, K_DARK, 0, 0, 0, 0, 0, 2);
      add(1, 1, 0, 0, K_C0,   0, 1, 8, 8, 0, 2);
      add(1, 1, 0, 1, K_NONE, 0, 0, 0, 0, 0, 2);
      add(641, 1, 0, 0, K_NONE, 0, 0, 0, 0, 0, 2);
      add(1, 1, 0, 0, K_C0,   0, 1, 639, 9, 0, 2);
      add(1, 1, 0, 0, K_C0,   0, 1, 639, 9, 0, 2);
      add(1, 1, 0, 0, K_C0,   1, 1, 639, 9, 0, 2);
      add(1, 1, 0, 1, K_NONE, 0, 0, 0, 0, 0, 2);
      add(1, 1, 1, 1, K_C0,   0, 1, 0, 0, 0, 0);
      add(1, 1, 0, 0, K_C0,   0, 1, 0, 1, 0, 0);
      add(1, 1, 0, 0, K_EDGE, 0, 1, 1, 1, 0, 2);
      add(1, 1, 0, 0, K_C0,   1, 1, 2, 1, 0, 2);
      add(1, 1, 0, 0, K_NONE, 0, 0, 0, 0, 0, 2);
      add(1, 1, 0, 0, K_C0,   0, 1, 4, 1, 0, 2);
      add(1, 1, 0, 0, K_C0,   0, 1, 5, 1, 0, 2);
      add(1, 1, 1, 0, K_C0,   0, 1, 0, 0, 0, 2);
      add(1, 1, 0, 0, K_C0,   0, 1, 1, 0, 0, 0);
      add(1, 1, 0, 1, K_NONE, 0, 0, 0, 0, 0, 2);
      add(478, 1, 0, 1, K_NONE, 0, 0, 0, 0, 0, 2);
      add(1, 1, 0, 0, K_C0,   0, 1, 0, 479, 0, 0);
      add(1, 1, 0, 0, K_C0,   0, 1, 1, 479, 0, 2);
      add(1, 1, 0, 1, K_C0,   1, 1, 2, 479, 0, 0);
      add(50, 1, 0, 0, K_C0,  0, 0, 0, 0, 0, 1);
      add(5, 1, 0, 1, K_C0,   0, 0, 0, 0, 0, 1);
      add(1, 1, 1, 0, K_C0,   0, 1, 0, 0, 0, 1);
      add(1, 1, 0, 0, K_C0,   0, 1, 1, 0, 0, 0);
      add(1, 1, 0, 0, K_C0,   1, 1, 2, 0, 0, 0);
      add(1, 1, 0, 0, K_NONE, 0, 0, 0, 0, 0, 2);

      // Reset held with random pixel traffic
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         pix_valid = 1'($urandom_range(0, 1));
         pix_sof = 1'($urandom_range(0, 1));
         pix_eol = 1'($urandom_range(0, 1));
         pix_y = 8'($urandom); pix_cr = 8'($urandom); pix_cb = 8'($urandom);
         check("reset_outputs_dut3", int'({flag3, x3, y3, c3, ff3}), 0);
         check("reset_outputs_dut1", int'({flag1, x1, y1, c1, ff1}), 0);
      end
      @(negedge clk);
      pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0;
      reset = 1'b1;

      foreach (vecs[k]) begin
         for (int r = 0; r < vecs[k].rep; r++) begin
            @(negedge clk);
            if (vecs[k].ff != 2) begin
               check($sformatf("frame_flag_dut3_row%0d", k), int'(ff3), vecs[k].ff);
               check($sformatf("frame_flag_dut1_row%0d", k), int'(ff1), vecs[k].ff);
            end
            pix_valid = vecs[k].v; pix_sof = vecs[k].sof; pix_eol = vecs[k].eol;
            set_pix(vecs[k].kind);
            if (vecs[k].e3) q3.push_back('{cyc + 2, vecs[k].ex, vecs[k].ey, vecs[k].ec});
            if (vecs[k].e1) q1.push_back('{cyc + 2, vecs[k].ex, vecs[k].ey, vecs[k].ec});
         end
      end

      // Reset one cycle after the third run pixel: pending reports vanish
      beat(0, 0, K_C0, 0, 1, 4, 0);
      beat(0, 0, K_C0, 0, 1, 5, 0);
      beat(0, 0, K_C0, 0, 0, 0, 0);
      @(negedge clk);
      pix_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("async_reset_dut3", int'({flag3, x3, y3, c3, ff3}), 0);
      check("async_reset_dut1", int'({flag1, x1, y1, c1, ff1}), 0);
      idle(2);
      reset = 1'b1;
      idle(4);
      check("post_reset_frame_flag", int'(ff3), 0);

      // Counters restart at (0,0) without a sof
      beat(0, 0, K_C0, 0, 1, 0, 0);
      beat(0, 0, K_C0, 0, 1, 1, 0);
      beat(0, 0, K_C0, 1, 1, 2, 0);
      idle(6);
      check("dut3_pending_pulses", q3.size(), 0);
      check("dut1_pending_pulses", q1.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
